cnn_window_feeder: RTL and testbench

//   Transmit side of the CNN window interface: holds a 28x28 8-bit image, walks every
//   5x5 window position, and drives X/Y/IMGIN/START into the CNN core one window at a time.

---
 rtl/cnn_window_feeder_if.sv | 48 ++++
 rtl/cnn_window_feeder.sv | 163 ++++++++++++++++
 tb/tb_cnn_window_feeder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/cnn_window_feeder_if.sv
// ---------------------------------------------------------------------------
// cnn_window_feeder_if
// Bundles the loader write port, the scan control handshake, the window bus
// towards the CNN core and the captured-result bus of cnn_window_feeder.
//   wr_en/wr_addr/wr_data : pixel write port (loader -> feeder)
//   go / busy             : scan request and scan-in-progress flag
//   start/x/y/imgin       : window issued to the CNN core
//   done/cnn_out          : core completion strobe and classification
//   res_valid/res_x/res_y/res_data : captured result with its coordinates
//   finish                : end-of-scan pulse
// Modports: master = feeder side, slave = loader/core/consumer side.
// ---------------------------------------------------------------------------
interface cnn_window_feeder_if #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 5,
  parameter int PIX_W = 8
);
  localparam int ADDR_W = $clog2(IMG_W * IMG_H);
  localparam int CRD_W  = $clog2(((IMG_W > IMG_H) ? IMG_W : IMG_H) - K + 1);

  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [PIX_W-1:0]       wr_data;
  logic                   go;
  logic                   busy;
  logic                   start;
  logic [CRD_W-1:0]       x;
  logic [CRD_W-1:0]       y;
  logic [K*K*PIX_W-1:0]   imgin;
  logic                   done;
  logic [3:0]             cnn_out;
  logic                   res_valid;
  logic [CRD_W-1:0]       res_x;
  logic [CRD_W-1:0]       res_y;
  logic [3:0]             res_data;
  logic                   finish;

  modport master (
    input  wr_en, wr_addr, wr_data, go, done, cnn_out,
    output busy, start, x, y, imgin, res_valid, res_x, res_y, res_data, finish
  );

  modport slave (
    output wr_en, wr_addr, wr_data, go, done, cnn_out,
    input  busy, start, x, y, imgin, res_valid, res_x, res_y, res_data, finish
  );
endinterface

// File: rtl/cnn_window_feeder.sv
// ---------------------------------------------------------------------------
// cnn_window_feeder
// Holds an IMG_W x IMG_H pixel image, walks every KxK window position in
// raster order (X fastest), gathers one window row per cycle, issues it to
// the CNN core with a START pulse, waits for DONE and captures the result
// together with the window coordinates. FINISH pulses once per scan.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : cnn_window_feeder_if.master (see interface header)
// ---------------------------------------------------------------------------
module cnn_window_feeder #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 5,
  parameter int PIX_W = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  cnn_window_feeder_if.master       bus
);
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int ADDR_W = $clog2(NPIX);
  localparam int NWIN_X = IMG_W - K + 1;
  localparam int NWIN_Y = IMG_H - K + 1;
  localparam int CRD_W  = $clog2(((IMG_W > IMG_H) ? IMG_W : IMG_H) - K + 1);
  localparam int ROW_W  = K * PIX_W;
  localparam int RCNT_W = $clog2(K);

  typedef enum logic [2:0] {
    S_IDLE, S_GATHER, S_ISSUE, S_WAIT, S_NEXT, S_FIN
  } state_t;

  state_t                 state_q;
  logic [PIX_W-1:0]       pix_mem [NPIX];
  logic [RCNT_W-1:0]      row_q;
  logic [CRD_W-1:0]       x_q;
  logic [CRD_W-1:0]       y_q;
  logic [K*K*PIX_W-1:0]   imgin_q;
  logic                   busy_q;
  logic                   start_q;
  logic                   res_valid_q;
  logic [CRD_W-1:0]       res_x_q;
  logic [CRD_W-1:0]       res_y_q;
  logic [3:0]             res_data_q;
  logic                   finish_q;

  logic                   wr_ok_s;
  logic                   last_win_s;
  logic [ADDR_W-1:0]      row_base_s;
  logic [ROW_W-1:0]       win_row_s;

  // The image may only change while no scan is running, so a window is
  // never assembled from a half-updated picture.
  assign wr_ok_s    = (state_q == S_IDLE) && bus.wr_en &&
                      (bus.wr_addr < ADDR_W'(NPIX));
  assign last_win_s = (x_q == CRD_W'(NWIN_X - 1)) && (y_q == CRD_W'(NWIN_Y - 1));
  assign row_base_s = (ADDR_W'(y_q) + ADDR_W'(row_q)) * ADDR_W'(IMG_W) + ADDR_W'(x_q);

  // Pixel storage, written from the loader port; intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (wr_ok_s) begin
      pix_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Fetch the K pixels of the window row currently being gathered.
  always_comb begin
    win_row_s = '0;
    for (int c = 0; c < K; c++) begin
      win_row_s[c*PIX_W +: PIX_W] = pix_mem[row_base_s + ADDR_W'(c)];
    end
  end

  // Scan sequencer: state, window origin, gathered window and result capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      imgin_q     <= '0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      res_data_q  <= 4'd0;
      finish_q    <= 1'b0;
    end else begin
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      finish_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // BUSY stays high through the FINISH cycle and drops here.
          busy_q <= bus.go;
          if (bus.go) begin
            x_q     <= '0;
            y_q     <= '0;
            row_q   <= '0;
            state_q <= S_GATHER;
          end
        end
        S_GATHER: begin
          for (int rr = 0; rr < K; rr++) begin
            if (row_q == RCNT_W'(rr)) begin
              imgin_q[rr*ROW_W +: ROW_W] <= win_row_s;
            end
          end
          if (row_q == RCNT_W'(K - 1)) begin
            start_q <= 1'b1;
            state_q <= S_ISSUE;
          end else begin
            row_q <= row_q + RCNT_W'(1);
          end
        end
        S_ISSUE: begin
          // A DONE seen here belongs to nothing we issued yet.
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.done) begin
            res_valid_q <= 1'b1;
            res_x_q     <= x_q;
            res_y_q     <= y_q;
            res_data_q  <= bus.cnn_out;
            state_q     <= last_win_s ? S_FIN : S_NEXT;
          end
        end
        S_NEXT: begin
          if (x_q == CRD_W'(NWIN_X - 1)) begin
            x_q <= '0;
            y_q <= y_q + CRD_W'(1);
          end else begin
            x_q <= x_q + CRD_W'(1);
          end
          row_q   <= '0;
          state_q <= S_GATHER;
        end
        S_FIN: begin
          finish_q <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.start     = start_q;
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.imgin     = imgin_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_x     = res_x_q;
  assign bus.res_y     = res_y_q;
  assign bus.res_data  = res_data_q;
  assign bus.finish    = finish_q;
endmodule

// File: tb/tb_cnn_window_feeder.sv
// ---------------------------------------------------------------------------
// tb_cnn_window_feeder
// Randomized self-checking bench for cnn_window_feeder. A reference image and
// the window/latency rules are kept in the bench; a responder answers each
// START with DONE after a random delay and a random OUT value.
// ---------------------------------------------------------------------------
module tb_cnn_window_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] img_m [784];

  cnn_window_feeder_if bus_if ();

  cnn_window_feeder dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Window contents straight from the definition pix(Y+r, X+c).
  function automatic logic [199:0] model_win(input int wx, input int wy);
    logic [199:0] w;
    w = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        w[(r*5+c)*8 +: 8] = img_m[(wy + r) * 28 + wx + c];
      end
    end
    return w;
  endfunction

  task automatic load_image(input bit pattern);
    logic [7:0] d;
    for (int a = 0; a < 784; a++) begin
      d = pattern ? 8'(a) : 8'($urandom);
      bus_if.wr_en   = 1'b1;
      bus_if.wr_addr = 10'(a);
      bus_if.wr_data = d;
      img_m[a] = d;
      tick();
    end
    // Out-of-range addresses must not land anywhere in the image.
    for (int i = 0; i < 24; i++) begin
      bus_if.wr_addr = 10'($urandom_range(784, 1023));
      bus_if.wr_data = 8'($urandom);
      tick();
    end
    bus_if.wr_en = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_imgin"}, bus_if.imgin, 200'd0);
    check_val({tag, "_ctl"}, {bus_if.busy, bus_if.start, bus_if.x, bus_if.y,
                              bus_if.res_valid, bus_if.res_x, bus_if.res_y,
                              bus_if.res_data, bus_if.finish}, 200'd0);
  endtask

  // One scan from GO. abort_idx >= 0 resets the DUT while that window waits.
  task automatic run_scan(input int abort_idx, input bit noise, input bit pattern_img);
    int win_idx = 0;
    int go_cyc, exp_start;
    int done_at = -1, rv_at = -1, fin_at = -1;
    int n_start = 0, n_rv = 0, n_fin = 0;
    int cur_x = 0, cur_y = 0, rv_x = 0, rv_y = 0;
    logic [3:0] rv_data = 4'd0;
    logic [199:0] win;
    bit aborted = 1'b0;
    go_cyc    = cyc;
    exp_start = cyc + 6;
    bus_if.go = 1'b1;
    forever begin
      tick();
      bus_if.go      = 1'b0;
      bus_if.done    = 1'b0;
      bus_if.wr_en   = 1'b0;
      bus_if.cnn_out = 4'($urandom);
      if (bus_if.start) n_start++;
      if (bus_if.res_valid) n_rv++;
      if (bus_if.finish) n_fin++;

      check_val("start", bus_if.start, cyc == exp_start);
      check_val("busy", bus_if.busy, (cyc > go_cyc) && (fin_at < 0 || cyc <= fin_at));
      check_val("finish", bus_if.finish, cyc == fin_at);
      check_val("res_valid", bus_if.res_valid, cyc == rv_at);
      if (rv_at >= 0 && cyc >= rv_at) begin
        check_val("res_x", bus_if.res_x, rv_x);
        check_val("res_y", bus_if.res_y, rv_y);
        check_val("res_data", bus_if.res_data, rv_data);
      end
      if (done_at >= cyc && cyc > exp_start) begin
        check_val("x_hold", bus_if.x, cur_x);
        check_val("y_hold", bus_if.y, cur_y);
      end

      if (cyc == exp_start) begin
        cur_x = win_idx % 24;
        cur_y = win_idx / 24;
        win   = bus_if.imgin;
        check_val("win_x", bus_if.x, cur_x);
        check_val("win_y", bus_if.y, cur_y);
        check_val("imgin", win, model_win(cur_x, cur_y));
        if (pattern_img && win_idx == 0) begin
          check_val("first_pix00", win[7:0], 8'd0);
          check_val("first_pix44", win[199:192], 8'd116);
        end
        if (pattern_img && win_idx == 24) begin
          check_val("wrap_x", bus_if.x, 5'd0);
          check_val("wrap_y", bus_if.y, 5'd1);
          check_val("wrap_pix00", win[7:0], 8'd28);
        end
        if (win_idx == abort_idx) begin
          tick();
          check_val("abort_wait_x", bus_if.x, cur_x);
          rst = 1'b1;
          #1;
          check_all_zero("abort_rst");
          for (int i = 0; i < 3; i++) begin
            tick();
            check_all_zero("abort_hold");
          end
          rst = 1'b0;
          aborted = 1'b1;
          break;
        end
        done_at = cyc + $urandom_range(1, 5);
        // Stray DONE during ISSUE must be ignored by the DUT.
        if ($urandom_range(0, 3) == 0) bus_if.done = 1'b1;
      end

      if (cyc == done_at) begin
        bus_if.done = 1'b1;
        rv_data = bus_if.cnn_out;
        rv_x    = cur_x;
        rv_y    = cur_y;
        rv_at   = cyc + 1;
        if (win_idx == 575) fin_at = cyc + 2;
        else exp_start = cyc + 7;
        win_idx++;
        done_at = -1;
      end else if (noise && done_at > cyc && cyc > exp_start) begin
        bus_if.wr_en   = 1'b1;
        bus_if.wr_addr = 10'($urandom_range(0, 783));
        bus_if.wr_data = 8'($urandom);
        bus_if.go      = 1'b1;
      end

      if (fin_at >= 0 && cyc == fin_at + 1) break;
      if (cyc - go_cyc > 12000) begin
        check_val("scan_timeout", win_idx, 576);
        break;
      end
    end
    bus_if.go    = 1'b0;
    bus_if.done  = 1'b0;
    bus_if.wr_en = 1'b0;
    if (!aborted) begin
      check_val("n_start", n_start, 576);
      check_val("n_res_valid", n_rv, 576);
      check_val("n_finish", n_fin, 1);
    end
  endtask

  initial begin
    bus_if.wr_en   = 1'b0;
    bus_if.wr_addr = 10'd0;
    bus_if.wr_data = 8'd0;
    bus_if.go      = 1'b0;
    bus_if.done    = 1'b0;
    bus_if.cnn_out = 4'd0;
    rst = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("post_reset");

    load_image(1'b1);
    run_scan(-1, 1'b0, 1'b1);
    tick();

    // Reset while window (5,2) is waiting for DONE.
    run_scan(2 * 24 + 5, 1'b0, 1'b1);
    tick();
    check_all_zero("after_abort");

    // Fresh image, then a scan with ignored writes/GO while busy.
    load_image(1'b0);
    run_scan(-1, 1'b1, 1'b0);
    tick();
    // Writes during the previous scan must not have altered the image.
    run_scan(-1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
